// File: rtl/multi_timer_if.sv
// Register-bus bundle between the nano6502 core and the multi_timer peripheral.
interface multi_timer_if;
  logic       timer_cs;
  logic       R_W_n;
  logic [4:0] reg_addr_i;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       irq_o;

  modport master (output timer_cs, R_W_n, reg_addr_i, data_i, input data_o, irq_o);
  modport slave  (input timer_cs, R_W_n, reg_addr_i, data_i, output data_o, irq_o);
endinterface

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with shared tick prescaler, sticky flags and a masked level IRQ.
// Optional free-running uptime counter at 0x12/0x13 when MULTI_TIMER_UPTIME_EN is defined.
module multi_timer #(
  parameter int CLK_FRE = 25_175_000,
  parameter int TICK_HZ = 1_000,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  multi_timer_if.slave  bus
);
  localparam int TICK_DIV = CLK_FRE / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);

  typedef enum logic {IDLE, RUNNING} state_t;

  logic [PW-1:0]     presc;
  logic              tick;
  logic              wr, rd, ch_space;
  logic [1:0]        ch_sel, off;
  state_t            state   [NUM_CH];
  logic [CNT_W-1:0]  count   [NUM_CH];
  logic [CNT_W-1:0]  reload  [NUM_CH];
  logic [7:0]        shadow  [NUM_CH];
  logic [15:0]       cnt_ext [NUM_CH];
  logic [15:0]       rld_ext [NUM_CH];
  logic [NUM_CH-1:0] periodic, flag, running, ch_wr, ch_rd, cmd_start, cmd_stop;
  logic [7:0]        irq_en, rdata;

  assign wr       = bus.timer_cs & ~bus.R_W_n;
  assign rd       = bus.timer_cs &  bus.R_W_n;
  assign ch_space = ~bus.reg_addr_i[4];
  assign ch_sel   = bus.reg_addr_i[3:2];
  assign off      = bus.reg_addr_i[1:0];
  assign tick     = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      running[c]   = (state[c] == RUNNING);
      cnt_ext[c]   = 16'(count[c]);
      rld_ext[c]   = 16'(reload[c]);
      ch_wr[c]     = wr & ch_space & (ch_sel == 2'(c));
      ch_rd[c]     = rd & ch_space & (ch_sel == 2'(c));
      cmd_start[c] = ch_wr[c] & (off == 2'd1) & bus.data_i[0];
      cmd_stop[c]  = ch_wr[c] & (off == 2'd1) & bus.data_i[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Channel FSMs; a flag set later in the loop body overrides a same-cycle W1C.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= IDLE;
        count[c]  <= '0;
        reload[c] <= '0;
        shadow[c] <= '0;
      end
      periodic <= '0;
      flag     <= '0;
      irq_en   <= '0;
    end else begin
      if (wr && bus.reg_addr_i == 5'h11) irq_en <= bus.data_i;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_wr[c]) begin
          case (off)
            2'd0:    periodic[c] <= bus.data_i[0];
            2'd2:    reload[c]   <= CNT_W'({rld_ext[c][15:8], bus.data_i});
            2'd3:    reload[c]   <= CNT_W'({bus.data_i, rld_ext[c][7:0]});
            default: ;
          endcase
        end
        if (ch_rd[c] && off == 2'd2) shadow[c] <= cnt_ext[c][15:8];
        if (wr && bus.reg_addr_i == 5'h10 && bus.data_i[c]) flag[c] <= 1'b0;
        if (cmd_stop[c]) begin
          state[c] <= IDLE;
        end else if (cmd_start[c]) begin
          if (reload[c] == '0) begin
            flag[c] <= 1'b1;
          end else begin
            count[c] <= reload[c];
            state[c] <= RUNNING;
          end
        end else if (state[c] == RUNNING && tick) begin
          if (count[c] == CNT_W'(1)) begin
            flag[c] <= 1'b1;
            if (periodic[c]) begin
              count[c] <= reload[c];
            end else begin
              count[c] <= '0;
              state[c] <= IDLE;
            end
          end else begin
            count[c] <= count[c] - CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef MULTI_TIMER_UPTIME_EN
  logic [15:0] uptime;
  logic [7:0]  up_shadow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      uptime    <= '0;
      up_shadow <= '0;
    end else begin
      if (wr && bus.reg_addr_i == 5'h12) uptime <= '0;
      else if (tick)                     uptime <= uptime + 16'd1;
      if (rd && bus.reg_addr_i == 5'h12) up_shadow <= uptime[15:8];
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (ch_space) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 2'(c)) begin
          case (off)
            2'd0: rdata = {7'd0, periodic[c]};
            2'd1: rdata = {6'd0, flag[c], running[c]};
            2'd2: rdata = cnt_ext[c][7:0];
            2'd3: rdata = shadow[c];
          endcase
        end
      end
    end else begin
      case (bus.reg_addr_i[3:0])
        4'h0:    rdata = 8'(flag);
        4'h1:    rdata = irq_en;
`ifdef MULTI_TIMER_UPTIME_EN
        4'h2:    rdata = uptime[7:0];
        4'h3:    rdata = up_shadow;
`endif
        default: rdata = '0;
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.data_o <= '0;
      bus.irq_o  <= 1'b0;
    end else begin
      bus.data_o <= rdata;
      bus.irq_o  <= |(flag & irq_en[NUM_CH-1:0]);
    end
  end
endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: reads push expected data, a negedge monitor pops and compares.
module tb_multi_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic rd_seen = 1'b0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;
  sb_t sbq[$];

  multi_timer_if bus();

  multi_timer #(.CLK_FRE(1000), .TICK_HZ(100), .NUM_CH(4), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_seen <= bus.timer_cs && bus.R_W_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      n_chk++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_underflow: data_o=0x%02h with no expected entry", bus.data_o);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        if (bus.data_o === e.exp) n_pass++;
        else $display("FAIL %s: data_o=0x%02h expected 0x%02h", e.name, bus.data_o, e.exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.timer_cs = 1'b1; bus.R_W_n = 1'b0; bus.reg_addr_i = a; bus.data_i = d;
    @(posedge clk); #1;
    bus.timer_cs = 1'b0; bus.R_W_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
    sb_t e;
    e.name = name; e.exp = exp;
    sbq.push_back(e);
    bus.timer_cs = 1'b1; bus.R_W_n = 1'b1; bus.reg_addr_i = a;
    @(posedge clk); #1;
    bus.timer_cs = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target - 1) begin @(posedge clk); #1; end
  endtask

  // Returns the edge index at which irq_o was first seen at lvl, or -1 on timeout.
  task automatic wait_irq(input logic lvl, input string name, output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.irq_o === lvl) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_chk++;
      $display("FAIL %s: irq_o never reached %0b within 100 cycles", name, lvl);
    end
  endtask

  initial begin
    int c0, a, a1, a2, ef, tick_ref, t;
    bus.timer_cs = 1'b0; bus.R_W_n = 1'b1; bus.reg_addr_i = '0; bus.data_i = '0;
    step(3);
    chk("reset_data_o", int'(bus.data_o), 0);
    chk("reset_irq_o", int'(bus.irq_o), 0);
    rst = 1'b0;
    step(2);
    rd(5'h01, 8'h00, "reset_cmd0");
    rd(5'h10, 8'h00, "reset_stat");
    rd(5'h14, 8'h00, "unmapped");

    // One-shot ch0 reload 3
    wr(5'h11, 8'h01);
    wr(5'h02, 8'h03);
    wr(5'h03, 8'h00);
    wr(5'h01, 8'h01);
    c0 = cyc;
    rd(5'h01, 8'h01, "os_running");
    wait_irq(1'b1, "os_expire", a);
    if (a >= 0) chk_range("os_latency", a - 1 - c0, 21, 30);
    rd(5'h01, 8'h02, "os_done");
    rd(5'h02, 8'h00, "os_cnt_l");
    rd(5'h03, 8'h00, "os_cnt_h");
    rd(5'h10, 8'h01, "os_stat");
    wr(5'h10, 8'h01);
    c0 = cyc;
    wait_irq(1'b0, "os_w1c", a);
    if (a >= 0) chk("w1c_irq_lat", a - c0, 1);

    // Periodic ch1 reload 2
    wr(5'h11, 8'h02);
    wr(5'h04, 8'h01);
    wr(5'h06, 8'h02);
    wr(5'h07, 8'h00);
    wr(5'h05, 8'h01);
    c0 = cyc;
    wait_irq(1'b1, "per_first", a1);
    if (a1 >= 0) chk_range("per_first_lat", a1 - 1 - c0, 11, 20);
    wr(5'h10, 8'h02);
    wait_irq(1'b0, "per_clear", a);
    wait_irq(1'b1, "per_second", a2);
    if (a1 >= 0 && a2 >= 0) chk("per_period", a2 - a1, 20);
    rd(5'h04, 8'h01, "per_ctrl");
    rd(5'h05, 8'h03, "per_cmd");
    wr(5'h05, 8'h02);
    rd(5'h05, 8'h02, "per_stopped");
    wr(5'h10, 8'h02);
    step(30);
    rd(5'h10, 8'h00, "per_halted");
    wr(5'h11, 8'h00);

    // IRQ masking and reload=0 immediate flag on ch2/ch3
    wr(5'h11, 8'h04);
    rd(5'h11, 8'h04, "irq_en_rb");
    wr(5'h09, 8'h01);
    chk("rz_irq_pre", int'(bus.irq_o), 0);
    step(1);
    chk("rz_irq_lat", int'(bus.irq_o), 1);
    rd(5'h09, 8'h02, "rz_idle_flag");
    wr(5'h10, 8'h04);
    step(1);
    chk("irq_w1c", int'(bus.irq_o), 0);
    wr(5'h0D, 8'h01);
    step(3);
    chk("flag3_masked", int'(bus.irq_o), 0);
    rd(5'h10, 8'h08, "flag3_stat");
    wr(5'h10, 8'h08);
    wr(5'h0A, 8'h01);
    wr(5'h09, 8'h01);
    c0 = cyc;
    wait_irq(1'b1, "r1_expire", a);
    if (a >= 0) chk_range("r1_latency", a - 1 - c0, 1, 10);
    wr(5'h10, 8'h04);

    // Start and stop together
    wr(5'h01, 8'h01);
    wr(5'h01, 8'h03);
    rd(5'h01, 8'h00, "ss_stop_wins");

    // W1C landing on the flag-set edge; ch2 periodic reload 1 sets every 10 cycles
    wr(5'h08, 8'h01);
    wr(5'h10, 8'hFF);
    wr(5'h09, 8'h01);
    wait_irq(1'b1, "w1c_sync", a);
    if (a < 0) a = cyc;
    ef = a - 1;
    tick_ref = ef;
    wr(5'h10, 8'h04);
    wait_to(ef + 20);
    wr(5'h10, 8'h04);
    rd(5'h10, 8'h04, "w1c_set_wins");
    wr(5'h10, 8'h04);
    rd(5'h10, 8'h00, "w1c_clears");
    wr(5'h09, 8'h02);
    wr(5'h08, 8'h00);
    wr(5'h10, 8'h04);
    wr(5'h11, 8'h00);

    // Snapshot ch3 reload 0x0105, start aligned with a tick edge
    wr(5'h0E, 8'h05);
    wr(5'h0F, 8'h01);
    t = tick_ref + 10 * ((cyc + 2 - tick_ref + 9) / 10);
    wait_to(t);
    wr(5'h0D, 8'h01);
    rd(5'h0E, 8'h05, "snap_l0");
    wait_to(t + 62);
    rd(5'h0F, 8'h01, "snap_h0");
    rd(5'h0E, 8'hFF, "snap_l1");
    rd(5'h0F, 8'h00, "snap_h1");
    wr(5'h0D, 8'h02);

    // Reset in the middle of a count
    wr(5'h11, 8'h01);
    wr(5'h01, 8'h01);
    bus.reg_addr_i = 5'h11;
    step(15);
    rst = 1'b1;
    #2;
    chk("rst_mid_data_o", int'(bus.data_o), 0);
    chk("rst_mid_irq_o", int'(bus.irq_o), 0);
    step(3);
    rst = 1'b0;
    rd(5'h01, 8'h00, "rst_ch0_idle");
    rd(5'h11, 8'h00, "rst_irq_en");
    step(40);
    chk("rst_no_irq", int'(bus.irq_o), 0);
    rd(5'h10, 8'h00, "rst_no_flag");
    rd(5'h02, 8'h00, "rst_cnt");

    @(negedge clk); #1;
    chk("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
